ser_piso_feed: RTL and testbench
================================

# ser_piso_feed

Parallel-in/serial-out feeder that turns WIDTH-bit words into the single-bit stream consumed by the serial sequence-detector stage. Sits directly upstream of the detector. Its `sout` drives the detector's serial `in` input, and both run on the same clock. Words arrive on a valid/ready handshake. A one-entry holding register lets back-to-back words stream with no idle bit between them.

## Interface
- `WIDTH`, default 8: word width in bits, ≥ 2.
- `IDLE_BIT`, default 1: level driven on `sout` when no word is being shifted.
- `clk  input  1`: clock; all state updates on the rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `din  input  WIDTH`: parallel word.
- `din_valid  input  1`: `din` holds a word to accept.
- `din_ready  output  1`: block can accept a word this cycle; equals `!rst && !hold_full`.
- `sout  output  1`: serial bit, registered.
- `sout_valid  output  1`: `sout` carries a data bit this cycle, registered.
- `word_done  output  1`: one-cycle pulse concurrent with the last bit of each word on `sout`, registered.
- `busy  output  1`: shifter or holding register occupied, registered.

## Operation
- **Transfer:** a transfer happens on an edge where `din_valid && din_ready`.
- **Storage:** shifter (WIDTH bits), bit counter (0..WIDTH-1), holding register plus `hold_full` flag.
- **FSM states:**
  - IDLE: shifter empty.
  - SHIFT: shifter emits one bit per cycle.
- **IDLE + transfer:** word loads into the shifter. Next state is SHIFT with counter = 0.
- **SHIFT, counter < WIDTH-1:** emit the current bit and increment the counter. A transfer writes the holding register and sets `hold_full`.
- **SHIFT, counter = WIDTH-1 (last bit):**
  - If `hold_full`: the holding word moves to the shifter, `hold_full` clears, counter = 0, and the state stays SHIFT.
  - Else, if a transfer occurs the same cycle: the incoming word loads the shifter directly, and the state stays SHIFT.
  - Else: next state is IDLE.
- **Bit order:** MSB first (see Configuration).
- **Output values:** `sout` = `IDLE_BIT` and `sout_valid` = 0 whenever no bit is being emitted.
- **`busy`:** 1 in SHIFT or while `hold_full`.
- **Holding capacity:** at most one word waits in the holding register. `din_ready` is low while it is full.
- **Data width:** `din` bits are never modified, and there is no arithmetic on data. The counter is `$clog2(WIDTH)` bits and wraps only by explicit reload to 0.

## Timing
- **Reset (edge with `rst` = 1):**
  - Outputs: `sout` = `IDLE_BIT`, `sout_valid` = 0, `word_done` = 0, `busy` = 0.
  - State: IDLE, counter = 0, `hold_full` = 0.
  - `din_ready` = 0 while `rst` is high and 1 in the first cycle after.
- **Latency:** for a word accepted at edge T into an empty block, bit 0 of the emitted sequence is on `sout` in the cycle after T. `sout_valid` is high for exactly WIDTH consecutive cycles. `word_done` is high in the WIDTH-th cycle.
- **Back-to-back streaming:** a word that is held, or accepted on the last-bit edge, starts the cycle immediately after the previous word's last bit. There is no gap and `sout_valid` stays high.
- **`din` change without transfer:** `din` changing while `din_ready` = 0 has no effect.
- **Reset mid-word:** both shifter and holding contents are discarded, with no partial `word_done`. `sout` returns to `IDLE_BIT` the cycle after the reset edge.
- **`din_valid` handling:** `din_valid` held high with no transfer causes no state change. `din_valid` may drop without a transfer; there is no stickiness.

## Configuration
- `SER_LSB_FIRST_EN` defined: bits are emitted LSB first, `din[0]` first and `din[WIDTH-1]` last.
- Not defined: MSB first, `din[WIDTH-1]` first. All timing is identical in both builds.

## Test plan
- **Reset values:** hold `rst` 3 cycles with `din_valid` = 1 → `din_ready` = 0, `sout` = 1, `sout_valid` = 0, `busy` = 0, no transfer.
- **Single word:** single word 8'b0110_0000 from idle (MSB first) → `sout` = 0,1,1,0,0,0,0,0 on cycles T+1..T+8, `sout_valid` high exactly those 8 cycles, `word_done` only at T+8. In the same run, feed `sout` to the detector and check it pulses for the 0110.
- **Back-to-back:** words 8'hA5 and 8'h3C presented consecutively → 16 contiguous valid bits 1010_0101_0011_1100. Third word 8'hFF is offered during the first word and is stalled with `din_ready` = 0 until 8'h3C moves from holding to shifter.
- **Direct load on last bit:** holding empty, transfer of 8'h81 exactly on the last-bit cycle of 8'h00 → no gap, `sout_valid` continuous for 16 cycles.
- **Reset mid-word:** assert `rst` after 4 bits of 8'hF0 with 8'h0F held → both words dropped, no `word_done`, `sout` = 1 next cycle. A subsequent word 8'h55 streams correctly.
- **LSB-first build:** with `SER_LSB_FIRST_EN`, send 8'b0000_0110 → `sout` = 0,1,1,0,0,0,0,0 with the same timing as the MSB-first case.

Source files
------------

// File: rtl/ser_piso_feed.sv
// ser_piso_feed: parallel-in / serial-out feeder for the serial
// sequence-detector stage. WIDTH-bit words arrive on a valid/ready
// handshake and are shifted out one bit per clock on sout. A one-entry
// holding register lets consecutive words stream with no idle bit between
// them.
//
// Build option: define SER_LSB_FIRST_EN to emit din[0] first; by default
// din[WIDTH-1] is emitted first. Timing is identical in both builds.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   din        in   parallel word (WIDTH bits)
//   din_valid  in   din holds a word to accept
//   din_ready  out  a word can be accepted this cycle (!rst && !hold_full)
//   sout       out  serial bit (IDLE_BIT when no word is being shifted)
//   sout_valid out  sout carries a data bit this cycle
//   word_done  out  pulse concurrent with the last bit of each word
//   busy       out  shifter or holding register occupied
module ser_piso_feed #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;        // index of the bit currently on sout
  logic [WIDTH-1:0] shreg;      // bits still to be emitted, next one in lead position
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  logic xfer;
  logic last;
  logic load_hold;
  logic load_din;
  logic hold_wr;

`ifdef SER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return w[0];
  endfunction

  function automatic logic [WIDTH-1:0] rest(input logic [WIDTH-1:0] w);
    return {1'b0, w[WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] rest(input logic [WIDTH-1:0] w);
    return {w[WIDTH-2:0], 1'b0};
  endfunction
`endif

  assign din_ready = !rst && !hold_full;

  always_comb begin
    xfer      = din_valid && din_ready;
    last      = (state == ST_SHIFT) && (cnt == CNT_LAST);
    // On the last-bit edge a held word has priority; din_ready is low then,
    // so a direct load can only happen with the holding register empty.
    load_hold = last && hold_full;
    load_din  = xfer && ((state == ST_IDLE) || (last && !hold_full));
    hold_wr   = xfer && (state == ST_SHIFT) && !last;
  end

  // Control: state, counter, handshake flag and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hold_full  <= 1'b0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
      word_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (load_hold || load_din) begin
        state      <= ST_SHIFT;
        cnt        <= '0;
        sout       <= load_hold ? first_bit(hold) : first_bit(din);
        sout_valid <= 1'b1;
        busy       <= 1'b1;
      end else if ((state == ST_SHIFT) && !last) begin
        cnt        <= cnt + CNT_W'(1);
        sout       <= first_bit(shreg);
        sout_valid <= 1'b1;
        word_done  <= (cnt == CNT_PENULT);
        busy       <= 1'b1;
      end else begin
        state      <= ST_IDLE;
        cnt        <= '0;
        sout       <= IDLE_BIT;
        sout_valid <= 1'b0;
        busy       <= 1'b0;
      end

      if (load_hold) begin
        hold_full <= 1'b0;
      end else if (hold_wr) begin
        hold_full <= 1'b1;
      end
    end
  end

  // Data: shifter and holding register carry no reset
  always_ff @(posedge clk) begin
    if (load_hold) begin
      shreg <= rest(hold);
    end else if (load_din) begin
      shreg <= rest(din);
    end else if (state == ST_SHIFT) begin
      shreg <= rest(shreg);
    end

    if (hold_wr) begin
      hold <= din;
    end
  end

endmodule

// File: tb/tb_ser_piso_feed.sv
// Testbench for ser_piso_feed: a word-queue model predicts every output each
// cycle, and directed scenarios pin that model with literal expectations.
module tb_ser_piso_feed;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         word_done;
  logic         busy;

  always #5 clk = ~clk;

  ser_piso_feed #(.WIDTH(W), .IDLE_BIT(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic bitof(input logic [W-1:0] w, input int p);
`ifdef SER_LSB_FIRST_EN
    return w[p];
`else
    return w[W-1-p];
`endif
  endfunction

  // Model: queue of accepted words not yet fully emitted; head is on sout
  // at bit position pos. At most one word may wait behind the head.
  logic [W-1:0] wq[$];
  int           pos = 0;
  bit           started = 0;

  always @(posedge clk) begin
    if (rst) begin
      wq.delete();
      pos = 0;
      started = 1;
    end else if (started) begin
      bit acc;
      acc = din_valid && (wq.size() < 2);
      if (wq.size() > 0) begin
        pos++;
        if (pos == W) begin
          void'(wq.pop_front());
          pos = 0;
        end
      end
      if (acc) wq.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic ev;
      ev = (wq.size() > 0);
      chk("sout_valid", 32'(sout_valid), 32'(ev));
      chk("sout", 32'(sout), 32'(ev ? bitof(wq[0], pos) : 1'b1));
      chk("word_done", 32'(word_done), 32'(ev && (pos == W - 1)));
      chk("busy", 32'(busy), 32'(ev));
      chk("din_ready", 32'(din_ready), 32'(!rst && (wq.size() < 2)));
    end
  end

  // Output log plus a behavioural 0110 detector fed from sout
  logic cap[$];
  int   runs = 0;
  int   wd_cnt = 0;
  logic prev_v = 1'b0;
  logic [3:0] det_sr = 4'hF;
  int   det_hits = 0;

  always @(negedge clk) begin
    if (started) begin
      if (sout_valid) cap.push_back(sout);
      if (sout_valid && !prev_v) runs++;
      prev_v = sout_valid;
      if (word_done) wd_cnt++;
      if (rst) det_sr = 4'hF;
      else begin
        det_sr = {det_sr[2:0], sout};
        if (det_sr == 4'b0110) det_hits++;
      end
    end
  end

  task automatic clear_log();
    cap.delete();
    runs = 0;
    wd_cnt = 0;
  endtask

  function automatic logic [31:0] cap_val(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], (i < cap.size()) ? cap[i] : 1'bx};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < 60), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sw;
    int h0;
    int nstall;

    // Reset held 3 cycles with din_valid high
    rst = 1'b1;
    din_valid = 1'b1;
    din = 8'hAA;
    repeat (3) step();
    chk("rst_ready", 32'(din_ready), 32'd0);
    chk("rst_sout", 32'(sout), 32'd1);
    chk("rst_valid", 32'(sout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(din_ready), 32'd1);
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single word, emitted order 0,1,1,0,0,0,0,0
    clear_log();
    h0 = det_hits;
`ifdef SER_LSB_FIRST_EN
    din = 8'b0000_0110;
`else
    din = 8'b0110_0000;
`endif
    sw = 8'b0110_0000;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("single_bit", 32'(sout), 32'(sw[W-1-i]));
      chk("single_done", 32'(word_done), 32'(i == W - 1));
      step();
    end
    chk("single_end_valid", 32'(sout_valid), 32'd0);
    chk("single_end_sout", 32'(sout), 32'd1);
    chk("single_nbits", 32'(cap.size()), 32'd8);
    chk("single_wd", 32'(wd_cnt), 32'd1);
    chk("det_hit", 32'(det_hits - h0), 32'd1);

    // Back-to-back A5, 3C with FF stalled behind the held word
    clear_log();
    din = 8'hA5;
    din_valid = 1'b1;
    step();
    din = 8'h3C;
    step();
    din = 8'hFF;
    chk("stall_ready", 32'(din_ready), 32'd0);
    nstall = 0;
    while (!din_ready && nstall < 20) begin
      step();
      nstall++;
    end
    chk("stall_cycles", 32'(nstall), 32'd7);
    step();
    din_valid = 1'b0;
    wait_idle();
    chk("b2b_nbits", 32'(cap.size()), 32'd24);
    chk("b2b_runs", 32'(runs), 32'd1);
    chk("b2b_wd", 32'(wd_cnt), 32'd3);
    chk("b2b_bits", cap_val(24), 32'h00A53CFF);

    // Direct load on the last-bit cycle
    clear_log();
    din = 8'h00;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (7) step();
    chk("direct_lastbit", 32'(word_done), 32'd1);
    chk("direct_ready", 32'(din_ready), 32'd1);
    din = 8'h81;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("direct_novgap", 32'(sout_valid), 32'd1);
    wait_idle();
    chk("direct_nbits", 32'(cap.size()), 32'd16);
    chk("direct_runs", 32'(runs), 32'd1);
    chk("direct_wd", 32'(wd_cnt), 32'd2);
    chk("direct_bits", cap_val(16), 32'h00000081);

    // Reset mid-word with a word held
    clear_log();
    din = 8'hF0;
    din_valid = 1'b1;
    step();
    din = 8'h0F;
    step();
    din_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sout", 32'(sout), 32'd1);
    chk("midrst_valid", 32'(sout_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) step();
    chk("midrst_nbits", 32'(cap.size()), 32'd5);
    chk("midrst_wd", 32'(wd_cnt), 32'd0);

    // Word after reset recovers cleanly
    clear_log();
    din = 8'h55;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    wait_idle();
    chk("after_nbits", 32'(cap.size()), 32'd8);
    chk("after_wd", 32'(wd_cnt), 32'd1);
`ifdef SER_LSB_FIRST_EN
    chk("after_bits", cap_val(8), 32'h000000AA);
`else
    chk("after_bits", cap_val(8), 32'h00000055);
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
